// File: rtl/mem_stage.sv
// Memory stage: issues data-memory loads/stores, waits for ack or timeout,
// and produces the writeback and forwarding results for the register file.
module mem_stage #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_valid,
  input  logic [7:0]  input_control,
  input  logic [31:0] input_ALU_result,
  input  logic [31:0] input_write_data,
  input  logic [4:0]  input_reg_addr,
  input  logic [1:0]  input_ls,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        t_wb_valid,
  output logic        t_wb_reg_write,
  output logic [4:0]  t_wb_reg_addr,
  output logic [31:0] t_wb_data,
  output logic [4:0]  output_mempro_addr,
  output logic [31:0] output_mempro_data,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  function automatic logic is_aligned(input logic [1:0] ls, input logic [1:0] a);
    case (ls)
      2'b01:   return ~a[0];
      2'b10:   return 1'b1;
      default: return (a == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] ls, input logic [1:0] a);
    case (ls)
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b0001 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] ls, input logic [31:0] wd);
    case (ls)
      2'b01:   return {2{wd[15:0]}};
      2'b10:   return {4{wd[7:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] ls, input logic [1:0] a,
                                               input logic [31:0] rd, input logic uns);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? rd[31:16] : rd[15:0];
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    case (ls)
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      2'b10:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      default: return rd;
    endcase
  endfunction

  state_t           state_p1, state_n;
  logic [CNT_W-1:0] cnt_p1;
  logic [31:0]      alu_p1;
  logic [4:0]       rd_p1;
  logic [1:0]       ls_p1;
  logic             rw_p1, m2r_p1, uns_p1;

  logic memop_in, aligned_in;
  logic capture, pass_wb, mis_wb, ack_hit, tmo_hit;
  logic [31:0] ld_data;
  logic unused_ctl;

  assign memop_in   = input_control[2] | input_control[3];
  assign aligned_in = is_aligned(input_ls, input_ALU_result[1:0]);
  assign unused_ctl = ^{input_control[7], input_control[1:0]};
  assign ld_data    = load_extract(ls_p1, alu_p1[1:0], mem_rdata, uns_p1);

  always_comb begin
    state_n = state_p1;
    capture = 1'b0;
    pass_wb = 1'b0;
    mis_wb  = 1'b0;
    ack_hit = 1'b0;
    tmo_hit = 1'b0;
    case (state_p1)
      S_IDLE: begin
        if (input_valid) begin
          if (!memop_in)        pass_wb = 1'b1;
          else if (!aligned_in) mis_wb  = 1'b1;
          else begin
            capture = 1'b1;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          ack_hit = 1'b1;
          state_n = S_IDLE;
        end else if (cnt_p1 == CNT_LAST) begin
          tmo_hit = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign stall              = (state_p1 == S_WAIT) | capture;
  assign output_mempro_addr = (t_wb_valid & t_wb_reg_write) ? t_wb_reg_addr : 5'd0;
  assign output_mempro_data = t_wb_data;

  always_ff @(posedge clk) begin
    if (rst) state_p1 <= S_IDLE;
    else     state_p1 <= state_n;
  end

  // Capture stage: the accepted access is held here for the whole WAIT phase
  always_ff @(posedge clk) begin
    if (capture) begin
      alu_p1 <= input_ALU_result;
      rd_p1  <= input_reg_addr;
      ls_p1  <= input_ls;
      rw_p1  <= input_control[4];
      m2r_p1 <= input_control[5];
      uns_p1 <= input_control[6];
    end
  end

  // Bus and writeback stage
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1         <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_be         <= '0;
      t_wb_valid     <= 1'b0;
      t_wb_reg_write <= 1'b0;
      t_wb_reg_addr  <= '0;
      t_wb_data      <= '0;
      misalign_err   <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      t_wb_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      if (capture) begin
        cnt_p1    <= '0;
        mem_req   <= 1'b1;
        mem_we    <= input_control[3];
        mem_addr  <= {input_ALU_result[31:2], 2'b00};
        mem_be    <= lane_enables(input_ls, input_ALU_result[1:0]);
        mem_wdata <= store_lanes(input_ls, input_write_data);
      end
      if (pass_wb || mis_wb) begin
        t_wb_valid     <= 1'b1;
        t_wb_reg_addr  <= input_reg_addr;
        t_wb_data      <= input_ALU_result;
        t_wb_reg_write <= pass_wb & input_control[4] & (|input_reg_addr);
        misalign_err   <= mis_wb;
      end
      if (ack_hit || tmo_hit) begin
        mem_req        <= 1'b0;
        mem_we         <= 1'b0;
        t_wb_valid     <= 1'b1;
        t_wb_reg_addr  <= rd_p1;
        t_wb_data      <= (ack_hit && m2r_p1) ? ld_data : alu_p1;
        t_wb_reg_write <= ack_hit & rw_p1 & (|rd_p1);
        bus_err        <= tmo_hit;
      end else if (state_p1 == S_WAIT) begin
        cnt_p1 <= cnt_p1 + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, is the maximum number of WAIT cycles without mem_ack before an access is abandoned.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 input_valid  input  1  the EX result presented this cycle is valid.
REQ-005 input_control  input  8  [2] mem_read, [3] mem_write, [4] reg_write, [5] mem_to_reg, [6] unsigned load; other bits ignored.
REQ-006 input_ALU_result  input  32  ALU result; the memory address for loads and stores.
REQ-007 input_write_data  input  32  store data.
REQ-008 input_reg_addr  input  5  destination register.
REQ-009 input_ls  input  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-010 mem_req, mem_we  output  1 each  data-memory request and write enable.
REQ-011 mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-012 mem_wdata  output  32  store data.
REQ-013 mem_be  output  4  byte enables.
REQ-014 mem_ack  input  1  access complete; mem_rdata is valid in the same cycle.
REQ-015 mem_rdata  input  32  read data.
REQ-016 stall  output  1  upstream must hold its outputs while high.
REQ-017 t_wb_valid, t_wb_reg_write  output  1 each  writeback strobe and register-write enable.
REQ-018 t_wb_reg_addr  output  5  writeback destination register.
REQ-019 t_wb_data  output  32  writeback data.
REQ-020 output_mempro_addr  output  5  forwarding register address to EX.
REQ-021 output_mempro_data  output  32  forwarding data to EX.
REQ-022 misalign_err, bus_err  output  1 each  single-cycle error pulses.

Function
REQ-023 The FSM SHALL have two states, IDLE and WAIT; memop = mem_read | mem_write.
REQ-024 IDLE, input_valid, no memop: at the next edge, t_wb_valid=1, t_wb_data=input_ALU_result, and t_wb_reg_addr/t_wb_reg_write follow the inputs; latency 1.
REQ-025 IDLE, input_valid, memop, aligned: capture all inputs and go to WAIT; mem_req=1 (registered) from the first WAIT cycle until ack or timeout.
REQ-026 Alignment: word requires addr[1:0]=0; half requires addr[0]=0; byte is always aligned.
REQ-027 Misaligned access: issue no mem_req, stay in IDLE, and at the next edge set t_wb_valid=1, t_wb_reg_write=0, misalign_err=1.
REQ-028 mem_be: word 1111; half 0011 if addr[1]=0, else 1100; byte 0001<<addr[1:0].
REQ-029 mem_wdata: word passes through; half is {2{wd[15:0]}}; byte is {4{wd[7:0]}}.
REQ-030 mem_we SHALL equal the captured mem_write, and is valid only while mem_req=1.
REQ-031 Load data:
  - select the byte or half by addr[1:0];
  - sign-extend, or zero-extend when control[6]=1.
REQ-032 When mem_ack is sampled in WAIT:
  - go to IDLE and drop mem_req;
  - t_wb_valid=1 at that edge;
  - t_wb_data = extracted load data if mem_to_reg=1, else the captured ALU result.
REQ-033 Minimum memop latency is 2 cycles: capture edge, then the ack edge.
REQ-034 A WAIT counter SHALL reset on entry; if it reaches MEM_TIMEOUT with no ack:
  - drop mem_req and go to IDLE;
  - pulse bus_err;
  - t_wb_valid=1 with t_wb_reg_write=0.
REQ-035 mem_ack in IDLE SHALL be ignored.
REQ-036 stall = (state==WAIT) | (state==IDLE & input_valid & memop & aligned), combinational.
REQ-037 While stall=1, no new input SHALL be accepted; the upstream holds its inputs, which are re-sampled after return to IDLE.
REQ-038 When t_wb_reg_addr=0, t_wb_reg_write SHALL be forced to 0.
REQ-039 t_wb_valid, misalign_err and bus_err SHALL be single-cycle pulses; t_wb_reg_addr and t_wb_data hold their values until the next writeback.
REQ-040 output_mempro_addr = t_wb_reg_addr when t_wb_valid & t_wb_reg_write, else 0; output_mempro_data = t_wb_data; both combinational from registers.
REQ-041 input_valid=0 in IDLE SHALL produce no writeback.

Reset
REQ-042 With rst=1 at an edge, all of the following SHALL take effect at that edge:
  - state becomes IDLE and the timeout counter clears;
  - mem_req, mem_we, t_wb_valid, t_wb_reg_write, misalign_err and bus_err become 0;
  - all data, address and be outputs become 0.
REQ-043 Reset in WAIT SHALL abandon the access; a mem_ack in the reset cycle is ignored and produces no writeback.

Verification
REQ-044 ALU pass-through: valid, control[4]=1, reg 5, result 0x1234 -> next cycle t_wb_valid=1, data 0x1234; mempro_addr=5; stall stays 0.
REQ-045 Signed byte load: addr 0x103, ls=10, rdata 0x80FF_FF00, ack on the 3rd WAIT cycle:
  - mem_be=1000;
  - t_wb_data=0xFFFF_FF80;
  - stall high for 4 cycles.
REQ-046 Half store: addr 0x202, wd 0xAABB_CCDD -> mem_be=1100, mem_wdata=0xCCDD_CCDD, mem_we=1; writeback has reg_write=0 after ack.
REQ-047 Misaligned word: addr 0x101, ls=00 -> mem_req never asserts; misalign_err pulses once; stall=0.
REQ-048 Timeout: MEM_TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then bus_err pulses and t_wb_reg_write=0.
REQ-049 Reset in WAIT with simultaneous ack -> next cycle state is IDLE, mem_req=0, t_wb_valid=0.
